sqrt_seq: RTL



---
 rtl/sqrt_pkg.sv | 25 ++
 rtl/sqrt_step.sv | 36 +++
 rtl/sqrt_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sequential square root unit.
package sqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Root width: one root bit per radicand bit pair.
    function automatic int root_width(input int data_w);
        return data_w / 2;
    endfunction

    // Remainder width: must hold 2*root, the largest possible remainder.
    function automatic int rem_width(input int root_w);
        return root_w + 1;
    endfunction

    // Iteration counter width, at least one bit even for a one-bit root.
    function automatic int cnt_width(input int root_w);
        return (root_w > 1) ? $clog2(root_w) : 1;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square root iteration (combinational).
// Brings in one radicand bit pair and decides the next root bit.
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int  ROOT_W = 8,
    localparam int REM_W  = rem_width(ROOT_W)
) (
    input  logic [REM_W-1:0]  prem,
    input  logic [ROOT_W-1:0] proot,
    input  logic [1:0]        pair,
    output logic [REM_W-1:0]  next_prem,
    output logic [ROOT_W-1:0] next_proot
);

    // One extra bit above the trial subtraction so its MSB is a clean sign.
    logic [ROOT_W+2:0] cur_s;
    logic [ROOT_W+2:0] sub_s;
    logic [ROOT_W+2:0] diff_s;
    logic              neg_s;
    logic [ROOT_W:0]   wide_root_s;
    logic              unused_s;

    assign cur_s       = {prem, pair};
    assign sub_s       = {1'b0, proot, 2'b01};
    assign diff_s      = cur_s - sub_s;
    assign neg_s       = diff_s[ROOT_W+2];
    // Negative trial restores the shifted remainder; it always fits REM_W bits.
    assign next_prem   = neg_s ? cur_s[ROOT_W:0] : diff_s[ROOT_W:0];
    // The partial root never reaches its top bit before the final step.
    assign wide_root_s = {proot, ~neg_s};
    assign next_proot  = wide_root_s[ROOT_W-1:0];
    // Bits that are provably zero for in-range operands.
    assign unused_s    = ^{diff_s[ROOT_W+1], wide_root_s[ROOT_W]};

endmodule

// File: rtl/sqrt_seq.sv
// Sequential integer square root: floor(sqrt(din)) and remainder,
// one root bit per clock, fixed latency of DATA_W/2 iterations.
module sqrt_seq
    import sqrt_pkg::*;
#(
    parameter int  DATA_W = 16,
    localparam int ROOT_W = root_width(DATA_W),
    localparam int REM_W  = rem_width(ROOT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [ROOT_W-1:0] root,
    output logic [REM_W-1:0]  rem
);

    localparam int              CNT_W    = cnt_width(ROOT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e              state_r;
    logic [DATA_W-1:0]   rad_r;
    logic [ROOT_W-1:0]   proot_r;
    logic [REM_W-1:0]    prem_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic                done_r;
    logic [ROOT_W-1:0]   root_r;
    logic [REM_W-1:0]    rem_r;

    logic [1:0]          pair_s;
    logic [ROOT_W-1:0]   nproot_s;
    logic [REM_W-1:0]    nprem_s;

    assign pair_s = rad_r[DATA_W-1 -: 2];

    sqrt_step #(
        .ROOT_W (ROOT_W)
    ) u_step (
        .prem       (prem_r),
        .proot      (proot_r),
        .pair       (pair_s),
        .next_prem  (nprem_s),
        .next_proot (nproot_s)
    );

    // Control FSM and datapath registers; outputs are registered here too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            rad_r   <= '0;
            proot_r <= '0;
            prem_r  <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            root_r  <= '0;
            rem_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (go) begin
                        rad_r   <= din;
                        proot_r <= '0;
                        prem_r  <= '0;
                        cnt_r   <= CNT_LAST;
                        busy_r  <= 1'b1;
                        state_r <= S_CALC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        // Cancel silently; published results stay untouched.
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        prem_r  <= nprem_s;
                        proot_r <= nproot_s;
                        rad_r   <= rad_r << 2;
                        cnt_r   <= cnt_r - CNT_ONE;
                        if (cnt_r == '0) begin
                            root_r  <= nproot_s;
                            rem_r   <= nprem_s;
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            state_r <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign root = root_r;
    assign rem  = rem_r;

endmodule
